tape_arbiter: RTL and testbench
===============================

TAPE_ARBITER -- requirements
Module: tape_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default `tape_addr_width, tape address width; DATA_WIDTH, default `tape_data_width, tape cell width.
REQ-002 Ports SHALL be as follows; the block has one clock, and reset is synchronous and active-high:
i_clock  in  1  system clock; all state updates on its rising edge
i_reset  in  1  synchronous, active-high reset
i_c_req  in  1  core access request
i_c_we  in  1  core write (1) / read (0)
i_c_addr  in  ADDR_WIDTH  core tape address
i_c_wdata  in  DATA_WIDTH  core write data
o_c_ack  out  1  core access complete, one-cycle pulse
o_c_rdata  out  DATA_WIDTH  core read data, valid while o_c_ack=1
i_h_req, i_h_we, i_h_addr, i_h_wdata, o_h_ack, o_h_rdata  same widths and meanings, host (loader/debugger) port
i_h_lock  in  1  host requests to keep ownership (used only when TAPE_ARB_HOST_LOCK_EN is defined)
o_ram_in  out  1  tape RAM write enable
o_ram_addr  out  ADDR_WIDTH  tape RAM address
o_ram_data  out  DATA_WIDTH  tape RAM write data
i_ram_data  in  DATA_WIDTH  tape RAM combinational read data
o_busy  out  1  an access is in flight (state != IDLE)

Function
REQ-003 The FSM SHALL have states IDLE, ACC_C, ACC_H, and ACK.
REQ-004 In IDLE, at the rising edge, with any eligible request, the block SHALL latch the winner's we/addr/wdata and move to ACC_C or ACC_H.
REQ-005 A requester SHALL be ineligible in any cycle in which its own ack is high.
REQ-006 Arbitration SHALL be round-robin: with only one eligible request, that requester wins; with both eligible, the requester not granted last wins.
REQ-007 In ACC_x, o_ram_addr and o_ram_data SHALL carry the latched values, and o_ram_in SHALL equal the latched we.
REQ-008 In all other states, o_ram_in SHALL be 0 and o_ram_addr/o_ram_data SHALL hold their last values.
REQ-009 At the rising edge ending ACC_x, the block SHALL capture i_ram_data into the rdata register of the winner, move to ACK, and pulse o_x_ack for exactly one cycle.
REQ-010 ACK SHALL return to IDLE unconditionally.
REQ-011 Request-to-ack latency SHALL be exactly 2 cycles when uncontended, and throughput SHALL be one access per 3 cycles.
REQ-012 rdata on a write access SHALL be the cell value read during the write cycle, which is the pre-write value.
REQ-013 Each o_x_rdata SHALL hold its value until that port's next ack.
REQ-014 Requesters SHALL hold req/we/addr/wdata stable until ack.
REQ-015 Dropping req before ack SHALL NOT abort an access in flight; the ack SHALL still be issued.
REQ-016 Simultaneous requests to the same address SHALL be serialised in grant order, so the second access sees the first access's write.
REQ-017 Address SHALL pass through unmodified, with no wrap logic; RAM size is 2^ADDR_WIDTH.

Reset
REQ-018 While i_reset is high at a rising edge, the FSM SHALL go to IDLE and last-grant SHALL be set to host, so the core wins the first tie.
REQ-019 Reset SHALL clear o_c_ack, o_h_ack, o_ram_in, o_busy, o_c_rdata, o_h_rdata, o_ram_addr, and o_ram_data to 0, and clear the lock flag.
REQ-020 Reset asserted during ACC_x SHALL suppress the pending ack, and no RAM write SHALL occur in any cycle in which i_reset=1.

Configuration
REQ-021 When TAPE_ARB_HOST_LOCK_EN is defined: if the host was granted and i_h_lock was 1 at its grant edge, the host SHALL win every subsequent tie while i_h_lock stays 1, so the core is stalled.
REQ-022 When TAPE_ARB_HOST_LOCK_EN is defined, the lock SHALL release at the first arbitration with i_h_lock=0.
REQ-023 When TAPE_ARB_HOST_LOCK_EN is undefined, i_h_lock SHALL be ignored and arbitration SHALL be pure round-robin.

Verification
REQ-024 Core-only write: core writes 0x5A to addr 3 -> o_ram_in=1 for exactly one cycle, o_c_ack 2 cycles after req, and a subsequent core read of addr 3 returns 0x5A.
REQ-025 Simultaneous requests out of reset: core reads addr 1, host writes 0x11 to addr 1 -> core acked first with the old value, host acked 3 cycles later, and a later core read returns 0x11.
REQ-026 Sustained contention for 12 cycles -> acks alternate C,H,C,H, and neither port waits more than 5 cycles.
REQ-027 Reset during ACC_H of a host write of 0xFF to addr 0 -> no ack, addr 0 unchanged, FSM in IDLE, and o_busy=0 the next cycle.
REQ-028 With TAPE_ARB_HOST_LOCK_EN defined, both requesting and i_h_lock=1 -> three consecutive host acks, then the core is granted at the first arbitration after i_h_lock drops.
REQ-029 With TAPE_ARB_HOST_LOCK_EN undefined, the same stimulus as REQ-028 -> acks alternate as in REQ-026.

Source files
------------

// File: rtl/tape_arbiter.sv
// tape_arbiter: two-port (core/host) round-robin arbiter in front of a
// single-port tape RAM with combinational read data. Each access takes
// IDLE -> ACC_x -> ACK, so the design completes one access every 3 cycles.
// Optional feature macro: TAPE_ARB_HOST_LOCK_EN. When it is defined, a host
// granted with i_h_lock=1 keeps winning ties while i_h_lock stays high.
`ifndef TAPE_ADDR_WIDTH
`define TAPE_ADDR_WIDTH 8
`endif
`ifndef TAPE_DATA_WIDTH
`define TAPE_DATA_WIDTH 8
`endif

module tape_arbiter #(
  parameter int ADDR_WIDTH = `TAPE_ADDR_WIDTH,
  parameter int DATA_WIDTH = `TAPE_DATA_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_c_req,
  input  logic                  i_c_we,
  input  logic [ADDR_WIDTH-1:0] i_c_addr,
  input  logic [DATA_WIDTH-1:0] i_c_wdata,
  output logic                  o_c_ack,
  output logic [DATA_WIDTH-1:0] o_c_rdata,
  input  logic                  i_h_req,
  input  logic                  i_h_we,
  input  logic [ADDR_WIDTH-1:0] i_h_addr,
  input  logic [DATA_WIDTH-1:0] i_h_wdata,
  output logic                  o_h_ack,
  output logic [DATA_WIDTH-1:0] o_h_rdata,
  input  logic                  i_h_lock,
  output logic                  o_ram_in,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic                  o_busy
);

  typedef enum logic [1:0] {IDLE, ACC_C, ACC_H, ACK} state_t;

  state_t                state_q, state_d;
  logic                  last_h_q, last_h_d;   // 1: host was granted last
  logic                  lock_q, lock_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  c_ack_q, c_ack_d;
  logic                  h_ack_q, h_ack_d;
  logic [DATA_WIDTH-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_WIDTH-1:0] h_rdata_q, h_rdata_d;

  logic c_elig, h_elig, lock_win, pick_h;

  // A port whose ack is showing this cycle cannot start another access.
  assign c_elig = i_c_req & ~c_ack_q;
  assign h_elig = i_h_req & ~h_ack_q;

`ifdef TAPE_ARB_HOST_LOCK_EN
  assign lock_win = lock_q & i_h_lock;
`else
  logic unused_h_lock;
  assign unused_h_lock = i_h_lock;
  assign lock_win      = 1'b0;
`endif

  // Host wins when alone, when the core went last, or while it holds the lock.
  assign pick_h = h_elig & (~c_elig | ~last_h_q | lock_win);

  // Next-state, grant latching, and read-data capture.
  always_comb begin
    state_d   = state_q;
    last_h_d  = last_h_q;
    lock_d    = lock_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_ack_d   = 1'b0;
    h_ack_d   = 1'b0;
    c_rdata_d = c_rdata_q;
    h_rdata_d = h_rdata_q;
    case (state_q)
      IDLE: begin
        if (c_elig | h_elig) begin
          last_h_d = pick_h;
`ifdef TAPE_ARB_HOST_LOCK_EN
          // Lock is armed on a host grant and dropped at the first
          // arbitration that sees i_h_lock low.
          lock_d = i_h_lock & (lock_q | pick_h);
`endif
          if (pick_h) begin
            state_d = ACC_H;
            we_d    = i_h_we;
            addr_d  = i_h_addr;
            wdata_d = i_h_wdata;
          end else begin
            state_d = ACC_C;
            we_d    = i_c_we;
            addr_d  = i_c_addr;
            wdata_d = i_c_wdata;
          end
        end
      end
      ACC_C: begin
        // RAM read is combinational, so this is the pre-write cell value.
        c_rdata_d = i_ram_data;
        c_ack_d   = 1'b1;
        state_d   = ACK;
      end
      ACC_H: begin
        h_rdata_d = i_ram_data;
        h_ack_d   = 1'b1;
        state_d   = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset also drops any access in flight and its ack.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      last_h_q  <= 1'b1;
      lock_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_ack_q   <= 1'b0;
      h_ack_q   <= 1'b0;
      c_rdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_h_q  <= last_h_d;
      lock_q    <= lock_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_ack_q   <= c_ack_d;
      h_ack_q   <= h_ack_d;
      c_rdata_q <= c_rdata_d;
      h_rdata_q <= h_rdata_d;
    end
  end

  // Address/data registers hold between accesses; writes never fire in reset.
  assign o_ram_in   = (state_q == ACC_C || state_q == ACC_H) & we_q & ~i_reset;
  assign o_ram_addr = addr_q;
  assign o_ram_data = wdata_q;
  assign o_c_ack    = c_ack_q;
  assign o_h_ack    = h_ack_q;
  assign o_c_rdata  = c_rdata_q;
  assign o_h_rdata  = h_rdata_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_tape_arbiter.sv
// Bench for tape_arbiter: directed scenarios with literal expectations plus a
// timing-level model (grant cycle g -> write in g+1, ack in g+2, free at g+3)
// checked against the DUT on every cycle after reset.
module tb_tape_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          c_req = 0, c_we = 0, h_req = 0, h_we = 0, h_lock = 0;
  logic [AW-1:0] c_addr = '0, h_addr = '0;
  logic [DW-1:0] c_wdata = '0, h_wdata = '0;
  logic          c_ack, h_ack, ram_in, busy;
  logic [DW-1:0] c_rdata, h_rdata, ram_wd, ram_rd;
  logic [AW-1:0] ram_addr;

  tape_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_ack(c_ack), .o_c_rdata(c_rdata),
    .i_h_req(h_req), .i_h_we(h_we), .i_h_addr(h_addr), .i_h_wdata(h_wdata),
    .o_h_ack(h_ack), .o_h_rdata(h_rdata), .i_h_lock(h_lock),
    .o_ram_in(ram_in), .o_ram_addr(ram_addr), .o_ram_data(ram_wd),
    .i_ram_data(ram_rd), .o_busy(busy));

  always #5 clk = ~clk;

  // Tape RAM: preloaded with i*3 on the first edge, then written on o_ram_in.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  bit pre_done = 1'b0;
  always @(posedge clk) begin
    if (!pre_done) begin
      for (int i = 0; i < (1<<AW); i++) ram[i] <= DW'(i*3);
      pre_done <= 1'b1;
    end else if (ram_in) ram[ram_addr] <= ram_wd;
  end
  assign ram_rd = ram[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- model ----------------
  logic [DW-1:0] smem [0:(1<<AW)-1];
  bit            s_init = 0, m_ok = 0;
  int            m_gc = -100, ph;
  bit            m_own, m_last = 1, m_lock = 0, m_we, pk;
  logic [AW-1:0] m_ra = '0;
  logic [DW-1:0] m_rd = '0, m_cr = '0, m_hr = '0;
  int            nwr = 0;
  int            ack_cyc[$];
  bit            ack_port[$];

  always @(negedge clk) begin
    if (!s_init) begin
      for (int i = 0; i < (1<<AW); i++) smem[i] = DW'(i*3);
      s_init = 1;
    end
    ph = cyc - m_gc;
    if (m_ok) begin
      chk("busy",     busy,     (ph == 1 || ph == 2));
      chk("ram_in",   ram_in,   (ph == 1 && m_we && !i_reset));
      chk("ram_addr", ram_addr, m_ra);
      chk("ram_data", ram_wd,   m_rd);
      chk("c_ack",    c_ack,    (ph == 2 && !m_own));
      chk("h_ack",    h_ack,    (ph == 2 && m_own));
      chk("c_rdata",  c_rdata,  m_cr);
      chk("h_rdata",  h_rdata,  m_hr);
    end
    if (ram_in) nwr++;
    if (c_ack) begin ack_cyc.push_back(cyc); ack_port.push_back(1'b0); end
    if (h_ack) begin ack_cyc.push_back(cyc); ack_port.push_back(1'b1); end
    // what the coming edge does
    if (i_reset) begin
      m_ok = 1; m_gc = -100; m_last = 1; m_lock = 0;
      m_cr = '0; m_hr = '0; m_ra = '0; m_rd = '0; m_we = 0;
    end else if (ph == 1) begin
      if (m_own) m_hr = smem[m_ra]; else m_cr = smem[m_ra];
      if (m_we) smem[m_ra] = m_rd;
    end else if (ph != 2 && (c_req || h_req)) begin
      pk = h_req && (!c_req || !m_last);
`ifdef TAPE_ARB_HOST_LOCK_EN
      if (h_req && m_lock && h_lock) pk = 1;
      m_lock = h_lock && (m_lock || pk);
`endif
      m_own = pk; m_last = pk; m_gc = cyc;
      m_we  = pk ? h_we : c_we;
      m_ra  = pk ? h_addr : c_addr;
      m_rd  = pk ? h_wdata : c_wdata;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic do_reset();
    i_reset = 1; tick(); tick(); i_reset = 0;
  endtask

  task automatic access(input bit host, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd);
    int c0;
    bit got;
    c0 = cyc; got = 0; lat = -1; rd = '0;
    if (host) begin h_req = 1; h_we = we; h_addr = a; h_wdata = d; end
    else      begin c_req = 1; c_we = we; c_addr = a; c_wdata = d; end
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (host ? h_ack : c_ack) begin
        got = 1; lat = cyc - c0; rd = host ? h_rdata : c_rdata;
      end
    end
    if (host) h_req = 0; else c_req = 0;
    if (!got) chk("ack_timeout", 0, 1);
  endtask

  // Checks the logged ack order against a port string and the per-port wait.
  task automatic chk_order(input string tag, input int c0, input int n,
                           input logic [7:0] pat);
    int prev [2];
    prev[0] = c0; prev[1] = c0;
    chk({tag, "_nacks"}, ack_cyc.size(), n);
    for (int i = 0; i < n && i < ack_cyc.size(); i++) begin
      chk({tag, "_port"}, ack_port[i], pat[i]);
      chk({tag, "_wait_le5"}, (ack_cyc[i] - prev[ack_port[i]]) <= 5, 1);
      prev[ack_port[i]] = ack_cyc[i] + 1;
    end
  endtask

  initial begin
    int lat, c0, ca, ha, mism;
    logic [DW-1:0] rd, crd;

    do_reset();
    chk("rst_busy",    busy,     0);
    chk("rst_c_rdata", c_rdata,  0);
    chk("rst_h_ack",   h_ack,    0);
    chk("rst_ram_addr", ram_addr, 0);

    // core-only write then read back
    nwr = 0;
    access(0, 1, 8'd3, 8'h5A, lat, rd);
    chk("wr_lat", lat, 2);
    tick();
    chk("wr_pulses", nwr, 1);
    access(0, 0, 8'd3, 8'h00, lat, rd);
    chk("rd_lat", lat, 2);
    chk("rd_data", rd, 8'h5A);
    tick();

    // simultaneous out of reset, same address
    do_reset();
    c0 = cyc; ca = -1; ha = -1; crd = '0;
    c_req = 1; c_we = 0; c_addr = 8'd1;
    h_req = 1; h_we = 1; h_addr = 8'd1; h_wdata = 8'h11;
    for (int i = 0; i < 12 && (ca < 0 || ha < 0); i++) begin
      tick();
      if (c_ack && ca < 0) begin ca = cyc; crd = c_rdata; c_req = 0; end
      if (h_ack && ha < 0) begin ha = cyc; h_req = 0; end
    end
    c_req = 0; h_req = 0;
    chk("sim_c_lat", ca - c0, 2);
    chk("sim_h_after_c", ha - ca, 3);
    chk("sim_c_old", crd, 8'h03);
    tick();
    access(0, 0, 8'd1, 8'h00, lat, rd);
    chk("sim_readback", rd, 8'h11);
    tick();

    // sustained contention, 12 cycles
    do_reset();
    ack_cyc.delete(); ack_port.delete();
    c0 = cyc;
    c_req = 1; c_we = 0; c_addr = 8'd2;
    h_req = 1; h_we = 1; h_addr = 8'd4; h_wdata = 8'h77;
    repeat (12) tick();
    c_req = 0; h_req = 0;
    repeat (3) tick();
    chk_order("rr", c0, 4, 8'b1010);

    // reset during the access cycle of a host write to addr 0
    access(1, 0, 8'd9, 8'h00, lat, rd);   // warm-up so grant is uncontended
    tick();
    h_req = 1; h_we = 1; h_addr = 8'd0; h_wdata = 8'hFF;
    tick();
    i_reset = 1; #1;
    chk("rst_acc_busy", busy, 1);
    chk("rst_acc_nowr", ram_in, 0);
    tick();
    i_reset = 0; h_req = 0;
    chk("rst_acc_noack", h_ack, 0);
    chk("rst_acc_idle", busy, 0);
    chk("rst_acc_mem0", ram[0], 8'h00);
    repeat (3) tick();

    // both requesting with host lock held, then lock dropped
    do_reset();
    ack_cyc.delete(); ack_port.delete();
    c0 = cyc;
    c_req = 1; c_we = 0; c_addr = 8'd6;
    h_req = 1; h_we = 1; h_addr = 8'd5; h_wdata = 8'h33; h_lock = 1;
    repeat (12) tick();
    h_lock = 0;
    repeat (3) tick();
    c_req = 0; h_req = 0;
    repeat (3) tick();
`ifdef TAPE_ARB_HOST_LOCK_EN
    chk_order("lock", c0, 5, 8'b01110);
`else
    chk_order("lock", c0, 5, 8'b01010);
`endif

    mism = 0;
    for (int i = 0; i < (1<<AW); i++) if (ram[i] !== smem[i]) mism++;
    chk("mem_image", mism, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
